// File: rtl/serial_frame_pkg.sv
// Shared types and helpers for the serial frame receiver and anything that
// models its framing rules.
package serial_frame_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        PARITY,
        STOP
    } state_t;

    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;

    localparam int unsigned MAX_DATA_W = 16;
    // Wide enough to index any legal data width.
    localparam int unsigned IDX_W = 5;

    // Value of the parity bit that makes the total count of ones even.
    function automatic logic even_parity(input logic [MAX_DATA_W-1:0] data);
        return ^data;
    endfunction

endpackage

// File: rtl/frame_out_reg.sv
// Single-entry valid/ready holding register for received words; decides
// whether a good frame loads or is dropped as an overrun.
module frame_out_reg #(
    parameter int unsigned DATA_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              frame_ok_i,
    input  logic [DATA_W-1:0] word_i,
    input  logic              data_ready_i,
    output logic [DATA_W-1:0] data_out_o,
    output logic              data_valid_o,
    output logic              loaded_o,
    output logic              overrun_o
);

    logic [DATA_W-1:0] data_q, data_d;
    logic              valid_q, valid_d;
    logic              accept;
    logic              slot_free;

    always_comb begin
        accept    = valid_q & data_ready_i;
        // A slot being drained this cycle can take the new word on the same edge.
        slot_free = ~valid_q | accept;
        loaded_o  = frame_ok_i & slot_free;
        overrun_o = frame_ok_i & ~slot_free;

        data_d  = data_q;
        valid_d = valid_q;
        if (loaded_o) begin
            data_d  = word_i;
            valid_d = 1'b1;
        end else if (accept) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

    assign data_out_o   = data_q;
    assign data_valid_o = valid_q;

endmodule

// File: rtl/serial_frame_receiver.sv
// Collects start / LSB-first data / optional even parity / stop frames into a
// parallel word, with sticky error flags and a delivered-frame counter.
module serial_frame_receiver
    import serial_frame_pkg::*;
#(
    parameter int unsigned DATA_W    = 4,
    parameter bit          PARITY_EN = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              bit_valid,
    input  logic              bit_in,
    output logic [DATA_W-1:0] data_out,
    output logic              data_valid,
    input  logic              data_ready,
    input  logic              err_clr,
    output logic              parity_err,
    output logic              frame_err,
    output logic              overrun,
    output logic [7:0]        frame_cnt
);

    state_t            state_q, state_d;
    logic [IDX_W-1:0]  bit_idx_q, bit_idx_d;
    logic [DATA_W-1:0] shreg_q, shreg_d;
    logic              pe_q, pe_d;
    logic              parity_err_q, parity_err_d;
    logic              frame_err_q, frame_err_d;
    logic              overrun_q, overrun_d;
    logic [7:0]        cnt_q, cnt_d;

    logic frame_ok;
    logic frame_bad;
    logic parity_bad;
    logic loaded;
    logic overrun_set;

    always_comb begin
        state_d    = state_q;
        bit_idx_d  = bit_idx_q;
        shreg_d    = shreg_q;
        pe_d       = pe_q;
        frame_ok   = 1'b0;
        frame_bad  = 1'b0;
        parity_bad = 1'b0;

        if (bit_valid) begin
            unique case (state_q)
                IDLE: begin
                    if (bit_in == START_BIT) begin
                        state_d   = DATA;
                        bit_idx_d = '0;
                        pe_d      = 1'b0;
                    end
                end
                DATA: begin
                    for (int i = 0; i < DATA_W; i++) begin
                        if (bit_idx_q == IDX_W'(i)) begin
                            shreg_d[i] = bit_in;
                        end
                    end
                    if (bit_idx_q == IDX_W'(DATA_W - 1)) begin
                        state_d = PARITY_EN ? PARITY : STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + IDX_W'(1);
                    end
                end
                PARITY: begin
                    pe_d    = (bit_in != even_parity(MAX_DATA_W'(shreg_q)));
                    state_d = STOP;
                end
                STOP: begin
                    state_d = IDLE;
                    if (bit_in != STOP_BIT) begin
                        frame_bad = 1'b1;
                    end else if (pe_q) begin
                        parity_bad = 1'b1;
                    end else begin
                        frame_ok = 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Sticky flags: a set in the same cycle as err_clr wins.
    always_comb begin
        frame_err_d  = frame_bad | (frame_err_q & ~err_clr);
        parity_err_d = parity_bad | (parity_err_q & ~err_clr);
        overrun_d    = overrun_set | (overrun_q & ~err_clr);
        cnt_d        = loaded ? cnt_q + 8'd1 : cnt_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            bit_idx_q    <= '0;
            shreg_q      <= '0;
            pe_q         <= 1'b0;
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
            overrun_q    <= 1'b0;
            cnt_q        <= '0;
        end else begin
            state_q      <= state_d;
            bit_idx_q    <= bit_idx_d;
            shreg_q      <= shreg_d;
            pe_q         <= pe_d;
            parity_err_q <= parity_err_d;
            frame_err_q  <= frame_err_d;
            overrun_q    <= overrun_d;
            cnt_q        <= cnt_d;
        end
    end

    frame_out_reg #(
        .DATA_W(DATA_W)
    ) u_out_reg (
        .clk          (clk),
        .reset        (reset),
        .frame_ok_i   (frame_ok),
        .word_i       (shreg_q),
        .data_ready_i (data_ready),
        .data_out_o   (data_out),
        .data_valid_o (data_valid),
        .loaded_o     (loaded),
        .overrun_o    (overrun_set)
    );

    assign parity_err = parity_err_q;
    assign frame_err  = frame_err_q;
    assign overrun    = overrun_q;
    assign frame_cnt  = cnt_q;

endmodule

// File: tb/tb_serial_frame_receiver.sv
// Directed bench for serial_frame_receiver: a frame-level reference model
// checked every cycle, plus literal expectations after each scenario.
module tb_serial_frame_receiver;
    import serial_frame_pkg::*;

    localparam int unsigned DW = 4;
    localparam bit          PE = 1'b1;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          bit_valid = 1'b0;
    logic          bit_in = 1'b1;
    logic          data_ready = 1'b1;
    logic          err_clr = 1'b0;
    logic [DW-1:0] data_out;
    logic          data_valid;
    logic          parity_err;
    logic          frame_err;
    logic          overrun;
    logic [7:0]    frame_cnt;

    always #5 clk = ~clk;

    serial_frame_receiver #(
        .DATA_W    (DW),
        .PARITY_EN (PE)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .bit_valid  (bit_valid),
        .bit_in     (bit_in),
        .data_out   (data_out),
        .data_valid (data_valid),
        .data_ready (data_ready),
        .err_clr    (err_clr),
        .parity_err (parity_err),
        .frame_err  (frame_err),
        .overrun    (overrun),
        .frame_cnt  (frame_cnt)
    );

    int n_cmp = 0;
    int n_bad = 0;
    bit cmp_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    // Frame-level model: the driver announces the word and its parity verdict
    // on the cycle it presents the stop bit.
    logic          stop_now = 1'b0;
    logic [DW-1:0] tx_word = '0;
    logic          tx_pbad = 1'b0;

    logic [DW-1:0] m_data;
    logic          m_valid, m_perr, m_ferr, m_ovr;
    logic [7:0]    m_cnt;

    wire m_acc  = m_valid && data_ready;
    wire m_good = stop_now && bit_in && !tx_pbad;
    wire m_load = m_good && (!m_valid || m_acc);

    always @(posedge clk) begin
        if (reset) begin
            m_data  <= '0;
            m_valid <= 1'b0;
            m_perr  <= 1'b0;
            m_ferr  <= 1'b0;
            m_ovr   <= 1'b0;
            m_cnt   <= '0;
        end else begin
            if (m_load) begin
                m_data  <= tx_word;
                m_valid <= 1'b1;
                m_cnt   <= m_cnt + 8'd1;
            end else if (m_acc) begin
                m_valid <= 1'b0;
            end
            m_ferr <= (stop_now && !bit_in) || (m_ferr && !err_clr);
            m_perr <= (stop_now && bit_in && tx_pbad) || (m_perr && !err_clr);
            m_ovr  <= (m_good && !m_load) || (m_ovr && !err_clr);
        end
    end

    always begin
        @(posedge clk);
        #1;
        if (cmp_en) begin
            check("data_valid", data_valid, m_valid);
            check("data_out", data_out, m_data);
            check("parity_err", parity_err, m_perr);
            check("frame_err", frame_err, m_ferr);
            check("overrun", overrun, m_ovr);
            check("frame_cnt", frame_cnt, m_cnt);
        end
    end

    task automatic drive_bit(input logic v, input logic b);
        @(negedge clk);
        bit_valid = v;
        bit_in    = b;
        stop_now  = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) drive_bit(1'b0, 1'b1);
    endtask

    task automatic send_bit(input logic b, input bit toggle);
        if (toggle) drive_bit(1'b0, 1'($urandom_range(0, 1)));
        drive_bit(1'b1, b);
    endtask

    task automatic send_frame(input logic [DW-1:0] d, input logic pbit, input logic sbit,
                              input bit toggle);
        send_bit(START_BIT, toggle);
        for (int i = 0; i < DW; i++) send_bit(d[i], toggle);
        if (PE) send_bit(pbit, toggle);
        if (toggle) drive_bit(1'b0, 1'($urandom_range(0, 1)));
        @(negedge clk);
        tx_word   = d;
        tx_pbad   = PE && (pbit != even_parity(MAX_DATA_W'(d)));
        bit_valid = 1'b1;
        bit_in    = sbit;
        stop_now  = 1'b1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset      = 1'b1;
        bit_valid  = 1'b0;
        bit_in     = 1'b1;
        stop_now   = 1'b0;
        err_clr    = 1'b0;
        data_ready = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("rst_valid", data_valid, 0);
        check("rst_data", data_out, 0);
        check("rst_flags", {parity_err, frame_err, overrun}, 0);
        check("rst_cnt", frame_cnt, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        logic [DW-1:0] d;

        do_reset();
        cmp_en = 1'b1;

        // 1: 4'hA, good parity, consumer ready
        send_frame(4'hA, 1'b0, 1'b1, 1'b0);
        idle(1);
        check("s1_valid", data_valid, 1);
        check("s1_data", data_out, 4'hA);
        check("s1_cnt", frame_cnt, 1);
        check("s1_flags", {parity_err, frame_err, overrun}, 0);
        idle(1);
        check("s1_valid_drop", data_valid, 0);

        // 2: 4'h7 with wrong parity bit, then clear
        do_reset();
        send_frame(4'h7, 1'b0, 1'b1, 1'b0);
        idle(1);
        check("s2_perr", parity_err, 1);
        check("s2_valid", data_valid, 0);
        check("s2_cnt", frame_cnt, 0);
        @(negedge clk);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        check("s2_perr_clr", parity_err, 0);

        // 3: bad stop bit, then good 4'h3 immediately
        do_reset();
        send_frame(4'h5, 1'b0, 1'b0, 1'b0);
        send_frame(4'h3, 1'b0, 1'b1, 1'b0);
        idle(1);
        check("s3_ferr", frame_err, 1);
        check("s3_valid", data_valid, 1);
        check("s3_data", data_out, 4'h3);
        check("s3_cnt", frame_cnt, 1);

        // 4: consumer stalled, second frame overruns
        do_reset();
        data_ready = 1'b0;
        send_frame(4'h3, 1'b0, 1'b1, 1'b0);
        send_frame(4'h5, 1'b0, 1'b1, 1'b0);
        idle(1);
        check("s4_data", data_out, 4'h3);
        check("s4_ovr", overrun, 1);
        check("s4_cnt", frame_cnt, 1);
        check("s4_valid", data_valid, 1);
        data_ready = 1'b1;
        idle(1);
        check("s4_valid_drop", data_valid, 0);

        // 5: bit_valid toggling with noise on invalid cycles
        do_reset();
        send_frame(4'hA, 1'b0, 1'b1, 1'b1);
        idle(1);
        check("s5_valid", data_valid, 1);
        check("s5_data", data_out, 4'hA);
        check("s5_cnt", frame_cnt, 1);
        check("s5_flags", {parity_err, frame_err, overrun}, 0);

        // 6: reset mid-frame, then 4'hC
        do_reset();
        send_bit(START_BIT, 1'b0);
        send_bit(1'b0, 1'b0);
        send_bit(1'b0, 1'b0);
        do_reset();
        send_frame(4'hC, 1'b0, 1'b1, 1'b0);
        idle(1);
        check("s6_data", data_out, 4'hC);
        check("s6_cnt", frame_cnt, 1);
        check("s6_flags", {parity_err, frame_err, overrun}, 0);

        // 256 good frames wrap the counter
        do_reset();
        for (int k = 0; k < 256; k++) begin
            d = DW'($urandom);
            send_frame(d, even_parity(MAX_DATA_W'(d)), 1'b1, 1'b0);
        end
        idle(2);
        check("wrap_cnt", frame_cnt, 0);
        check("wrap_flags", {parity_err, frame_err, overrun}, 0);

        idle(1);
        cmp_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/serial_frame_receiver.md
Name: serial_frame_receiver

Overview:
Consumer stage for the serial output of the 4-bit universal shift register (s_right/s_left). It collects a framed bit stream (start, data LSB-first, optional even parity, stop) into a parallel word. It presents the word on a valid/ready interface, flags parity, framing and overrun errors, and counts delivered frames. It also serves as the serial-to-parallel check point for shift-register datapaths.

Parameters:
DATA_W, 4, data bits per frame (range 1..16).
PARITY_EN, 1, 1 = frame carries an even-parity bit after the data bits; 0 = no parity bit.

Ports:
clk  input  1  clock, all logic on rising edge
reset  input  1  synchronous, active-high reset
bit_valid  input  1  bit_in is sampled this cycle; when low, receiver holds state
bit_in  input  1  serial bit (from shift register s_right/s_left)
data_out  output  DATA_W  received word, stable while data_valid=1
data_valid  output  1  data_out holds an undelivered word
data_ready  input  1  consumer accepts; transfer when data_valid&&data_ready
err_clr  input  1  clears the sticky error flags
parity_err  output  1  sticky: parity mismatch seen
frame_err  output  1  sticky: stop bit sampled as 0
overrun  output  1  sticky: good frame dropped because output was still full
frame_cnt  output  8  count of frames delivered to data_out, wraps FF->00

Behaviour:
- Reset: reset, synchronous, active-high; clock clk. All outputs 0; FSM to IDLE; bit index 0; shift register 0. Reset mid-frame abandons the frame with no flags.
- FSM states are IDLE, DATA, PARITY, STOP. Transitions happen only on cycles with bit_valid=1. With bit_valid=0, all state and the shift register hold.
- IDLE: bit_in=0 -> DATA, bit index=0. bit_in=1 -> stay (line idle high).
- DATA: bit_in is written to shreg[bit index], LSB first. After bit index DATA_W-1 -> PARITY if PARITY_EN, else STOP.
- PARITY: the sampled bit is compared with the XOR of the data bits. A mismatch sets an internal pe flag for this frame. -> STOP.
- STOP, on a valid bit, always -> IDLE. Priority of the checks:
  - bit_in=0: frame_err<=1, word dropped.
  - else pe: parity_err<=1, word dropped.
  - else output slot free, or freed this same cycle by data_valid&&data_ready: data_out<=shreg, data_valid<=1, frame_cnt<=frame_cnt+1.
  - else: overrun<=1, word dropped, data_out unchanged.
- Latency: data_valid rises the cycle after the edge that samples a good stop bit. Back-to-back frames need no idle bit; a start bit may follow the stop bit immediately.
- Handshake: data_valid falls the cycle after data_valid&&data_ready, unless a new word loads on that same edge, in which case data_valid stays 1 with the new data_out. data_out never changes while data_valid=1 and data_ready=0.
- Error flags: sticky until err_clr. If a set and err_clr occur in the same cycle, the set wins. Flags do not stall reception.
- frame_cnt: 8-bit modular. It counts only loaded words, not dropped ones.

Decomposition:
- Shared package serial_frame_pkg holds:
  - enum state_t {IDLE, DATA, PARITY, STOP}
  - constants START_BIT=1'b0 and STOP_BIT=1'b1
  - a function even_parity(data) used by both the RTL and the bench model.
- One sub-module, frame_out_reg: the single-entry valid/ready holding register with its load/accept/overrun logic. The FSM stays in the top module.

Test Plan:
1. DATA_W=4, PARITY_EN=1, data_ready=1. Send bits 0,0,1,0,1,0,1 with bit_valid=1 each cycle -> data_out=4'hA, data_valid high exactly one cycle after the stop edge, frame_cnt=1, all flags 0.
2. Send 4'h7 frame with a wrong parity bit: 0,1,1,1,0,0,1 -> parity_err=1, data_valid stays 0, frame_cnt unchanged. Then pulse err_clr -> parity_err=0 the next cycle.
3. Send the 4'h5 frame (0,1,0,1,0,0) with stop bit 0 -> frame_err=1, no output. Then send a valid 4'h3 frame immediately -> data_out=4'h3 and frame_err still 1.
4. With data_ready=0, send frames 4'h3 then 4'h5 back-to-back -> data_out stays 4'h3, overrun=1, frame_cnt=1. Then raise data_ready -> data_valid drops the next cycle.
5. Send the 4'hA frame with bit_valid toggled 1/0 every cycle and random bit_in on the invalid cycles -> same result as scenario 1.
6. Assert reset after the 2nd data bit, then send a 4'hC frame -> data_out=4'hC, frame_cnt=1, no flags. Also run 256 good frames and check frame_cnt wraps to 0.
